// File: rtl/dmem_refill_responder.sv
// Main-memory side of the D-cache refill interface: fixed-latency line refills plus write-through stores.
// Optional build macro: DMEM_CRITICAL_WORD_FIRST_EN (refill starts at the requested word and wraps).
module dmem_refill_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LINE_WORDS  = 4,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = IDX_W - OFF_W;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } stateT;

    logic [31:0]      mem [DEPTH_WORDS];
    stateT            state;
    logic [TAG_W-1:0] lineTag;
    logic [OFF_W-1:0] startOff;
    logic [OFF_W-1:0] beatCnt;
    logic [CNT_W-1:0] waitCnt;

    logic [IDX_W-1:0] reqIdx;
    logic [IDX_W-1:0] wrIdx;
    logic [IDX_W-1:0] beatIdx;
    logic [OFF_W-1:0] reqOff;
    logic [31:0]      beatData;
    logic             unusedBits;

    assign reqIdx = req_addr[IDX_W+1:2];
    assign wrIdx  = wr_addr[IDX_W+1:2];

`ifdef DMEM_CRITICAL_WORD_FIRST_EN
    assign reqOff     = reqIdx[OFF_W-1:0];
    assign unusedBits = ^{req_addr[31:IDX_W+2], req_addr[1:0], wr_addr[31:IDX_W+2], wr_addr[1:0]};
`else
    assign reqOff     = '0;
    assign unusedBits = ^{req_addr[31:IDX_W+2], req_addr[1:0], wr_addr[31:IDX_W+2], wr_addr[1:0],
                          reqIdx[OFF_W-1:0]};
`endif

    // Beat offset wraps inside the line because it is only OFF_W bits wide.
    assign beatIdx = {lineTag, startOff + beatCnt};

    // A store landing on the same edge as the beat launch is forwarded so the beat sees the new value.
    assign beatData = (wr_en && (wrIdx == beatIdx)) ? wr_data : mem[beatIdx];

    // NOTE: the storage array has no reset; clearing it would need a per-word reset network and rst must not erase stores.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wrIdx] <= wr_data;
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            busy      <= 1'b0;
            lineTag   <= '0;
            startOff  <= '0;
            beatCnt   <= '0;
            waitCnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lineTag   <= reqIdx[IDX_W-1:OFF_W];
                        startOff  <= reqOff;
                        beatCnt   <= '0;
                        waitCnt   <= WAIT_LOAD;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (waitCnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= beatData;
                        rsp_last  <= (beatCnt == LAST_BEAT);
                        beatCnt   <= beatCnt + OFF_W'(1);
                        state     <= S_BURST;
                    end else begin
                        waitCnt <= waitCnt - CNT_W'(1);
                    end
                end
                S_BURST: begin
                    if (rsp_last) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= beatData;
                        rsp_last  <= (beatCnt == LAST_BEAT);
                        beatCnt   <= beatCnt + OFF_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_refill_responder.sv
// Self-checking bench for dmem_refill_responder: randomized refills and stores against a word-array model.
// Follows DMEM_CRITICAL_WORD_FIRST_EN so the same bench serves both builds.
module tb_dmem_refill_responder;

    localparam int DEPTH = 1024;
    localparam int LINE  = 4;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] refMem [DEPTH];

    localparam logic [35:0] IDLE_OBS = {1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

    dmem_refill_responder #(
        .DEPTH_WORDS(DEPTH),
        .LINE_WORDS (LINE),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_last (rsp_last),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int wordIdx(input logic [31:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    function automatic int startOffset(input logic [31:0] a);
`ifdef DMEM_CRITICAL_WORD_FIRST_EN
        return wordIdx(a) % LINE;
`else
        return 0;
`endif
    endfunction

    function automatic logic [35:0] observed();
        return {rsp_valid, rsp_last, req_ready, busy, rsp_data};
    endfunction

    // One clock: the model memory takes the store seen at the edge, then outputs settle for sampling.
    task automatic step();
        @(posedge clk);
        if (wr_en) refMem[wordIdx(wr_addr)] = wr_data;
        #1;
    endtask

    task automatic drive_random_store(input int base);
        int idx;
        if ($urandom_range(1, 0) == 1) begin
            idx     = ($urandom_range(1, 0) == 1) ? base + $urandom_range(LINE - 1, 0)
                                                  : $urandom_range(DEPTH - 1, 0);
            wr_en   = 1'b1;
            wr_addr = ($urandom() & 32'hFFFF_F003) | (32'(idx) << 2);
            wr_data = $urandom();
        end else begin
            wr_en = 1'b0;
        end
    endtask

    // Issue one refill and check every cycle from the accept edge until the responder is idle again.
    task automatic run_refill(input string name, input logic [31:0] addr, input bit hold,
                              input bit randStores, input int dirEdge, input logic [31:0] dirAddr,
                              input logic [31:0] dirData, input int abortBeat);
        int base;
        int start;
        int k;
        logic [35:0] obs;
        logic [35:0] exp;
        base      = wordIdx(addr) - (wordIdx(addr) % LINE);
        start     = startOffset(addr);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int e = 0; e <= LAT + LINE; e++) begin
            if (e == dirEdge) begin
                wr_en   = 1'b1;
                wr_addr = dirAddr;
                wr_data = dirData;
            end else if (randStores) begin
                drive_random_store(base);
            end else begin
                wr_en = 1'b0;
            end
            if (e > 0 && hold) req_addr = $urandom();
            step();
            if (e == 0 && !hold) req_valid = 1'b0;
            k = e - LAT;
            if (e < LAT)
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
            else if (e < LAT + LINE)
                exp = {1'b1, (k == LINE - 1), 1'b0, 1'b1, refMem[base + ((start + k) % LINE)]};
            else
                exp = IDLE_OBS;
            obs = observed();
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s edge=%0d: got %h want %h", name, e, obs, exp);
            end
            if (e >= LAT && k == abortBeat) begin
                req_valid = 1'b0;
                wr_en     = 1'b1;
                wr_addr   = 32'(base + ((start + k + 1) % LINE)) << 2;
                wr_data   = 32'h5EED_0000 | 32'(k);
                #2 rst = 1'b1;
                #1;
                obs = observed();
                total++;
                if (obs !== IDLE_OBS) begin
                    bad++;
                    $display("FAIL %s abort: got %h want %h", name, obs, IDLE_OBS);
                end
                step();
                wr_en = 1'b0;
                step();
                rst = 1'b0;
                for (int c = 0; c < LAT + LINE + 2; c++) begin
                    step();
                    obs = observed();
                    total++;
                    if (obs !== IDLE_OBS) begin
                        bad++;
                        $display("FAIL %s post-abort c=%0d: got %h want %h", name, c, obs, IDLE_OBS);
                    end
                end
                return;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        step();
        step();
        obs = observed();
        total++;
        if (obs !== IDLE_OBS) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", obs, IDLE_OBS);
        end
        rst = 1'b0;
        step();
        obs = observed();
        total++;
        if (obs !== IDLE_OBS) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs, IDLE_OBS);
        end
    endtask

    task automatic test_preload();
        logic [35:0] obs;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 32'(i) << 2;
            wr_data = (i >= 8 && i < 12) ? (32'hA0A0_0000 | 32'(i - 8)) : $urandom();
            step();
        end
        wr_en = 1'b0;
        obs = observed();
        total++;
        if (obs !== IDLE_OBS) begin
            bad++;
            $display("FAIL preload_idle: got %h want %h", obs, IDLE_OBS);
        end
    endtask

    task automatic test_mid_reset();
        logic [35:0] obs;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0100;
        step();
        req_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        obs = observed();
        total++;
        if (obs !== IDLE_OBS) begin
            bad++;
            $display("FAIL reset_mid_wait: got %h want %h", obs, IDLE_OBS);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < LAT + LINE; c++) begin
            step();
            obs = observed();
            total++;
            if (obs !== IDLE_OBS) begin
                bad++;
                $display("FAIL reset_mid_quiet c=%0d: got %h want %h", c, obs, IDLE_OBS);
            end
        end
    endtask

    task automatic test_basic();
        run_refill("basic_0x24", 32'h0000_0024, 1'b0, 1'b0, -1, '0, '0, -1);
        run_refill("basic_0x20", 32'h0000_0020, 1'b0, 1'b0, -1, '0, '0, -1);
    endtask

    task automatic test_collision();
        int kA3;
        kA3 = (3 - startOffset(32'h0000_0024) + LINE) % LINE;
        run_refill("collide", 32'h0000_0024, 1'b0, 1'b0, LAT + kA3, 32'h0000_002C, 32'hDEAD_BEEF, -1);
        run_refill("collide_later", 32'h0000_0028, 1'b0, 1'b0, -1, '0, '0, -1);
        total++;
        if (refMem[11] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL collide_model: got %h want %h", refMem[11], 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_back_to_back();
        run_refill("b2b_first", $urandom(), 1'b1, 1'b1, -1, '0, '0, -1);
        run_refill("b2b_second", $urandom(), 1'b1, 1'b1, -1, '0, '0, -1);
        run_refill("b2b_third", $urandom(), 1'b0, 1'b1, -1, '0, '0, -1);
    endtask

    task automatic test_wrap();
        run_refill("wrap_abort", 32'hFFFF_FFF0, 1'b0, 1'b0, -1, '0, '0, 2);
        run_refill("wrap_full", 32'hFFFF_FFF4, 1'b0, 1'b1, -1, '0, '0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_refill("random", $urandom(), (i != 24) && ($urandom_range(1, 0) == 1), 1'b1,
                       -1, '0, '0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_mid_reset();
        test_basic();
        test_collision();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
